// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: two buffered producers share the register-file write port.
// Ports: clk/rst; A and B valid/ready push; wb_* write port; q_* pending query.
module regfile_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [4:0]       a_rd,
    input  logic [31:0]      a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [4:0]       b_rd,
    input  logic [31:0]      b_data,
    output logic             wb_we,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    input  logic [4:0]       q_rs1,
    input  logic [4:0]       q_rs2,
    output logic             q_pend1,
    output logic             q_pend2,
    output logic [CNT_W-1:0] wb_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]  rd_q  [2][DEPTH];
    logic [31:0] dat_q [2][DEPTH];

    logic [1:0][AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic               en_q;
    logic               last_q;
    logic [CNT_W-1:0]   wbc_q, wbc_d;

    logic [1:0]         vld, rdy, push, hv, gnt;
    logic [1:0][4:0]    in_rd;
    logic [1:0][31:0]   in_dat;
    logic [AW-1:0]      off;

    assign vld    = {b_valid, a_valid};
    assign in_rd  = {b_rd, a_rd};
    assign in_dat = {b_data, a_data};

    // en_q keeps both readies low until the first edge after reset release
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdy[p] = en_q && (cnt_q[p] != CW'(DEPTH));
            hv[p]  = cnt_q[p] != '0;
        end
    end

    assign a_ready = rdy[0];
    assign b_ready = rdy[1];
    assign push    = vld & rdy;

    // last_q = 1 means B was granted last, so A wins a contest
    assign gnt[0] = hv[0] && (!hv[1] || last_q);
    assign gnt[1] = hv[1] && !gnt[0];

    always_comb begin
        wb_we   = 1'b0;
        wb_rd   = '0;
        wb_data = '0;
        unique case (1'b1)
            gnt[0]: begin
                wb_rd   = rd_q[0][rp_q[0]];
                wb_data = dat_q[0][rp_q[0]];
                wb_we   = wb_rd != '0;
            end
            gnt[1]: begin
                wb_rd   = rd_q[1][rp_q[1]];
                wb_data = dat_q[1][rp_q[1]];
                wb_we   = wb_rd != '0;
            end
            default: ;
        endcase
    end

    // an entry is live when its distance from the head is below occupancy
    always_comb begin
        q_pend1 = 1'b0;
        q_pend2 = 1'b0;
        off     = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                off = AW'(i) - rp_q[p];
                if ({1'b0, off} < cnt_q[p]) begin
                    if (rd_q[p][i] == q_rs1) q_pend1 = 1'b1;
                    if (rd_q[p][i] == q_rs2) q_pend2 = 1'b1;
                end
            end
        end
        q_pend1 = q_pend1 && (q_rs1 != '0);
        q_pend2 = q_pend2 && (q_rs2 != '0);
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            wp_d[p]  = wp_q[p] + AW'(push[p]);
            rp_d[p]  = rp_q[p] + AW'(gnt[p]);
            cnt_d[p] = cnt_q[p] + CW'(push[p]) - CW'(gnt[p]);
        end
        wbc_d = wbc_q;
        if (wb_we && (wbc_q != '1)) wbc_d = wbc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            en_q   <= 1'b0;
            last_q <= 1'b1;
            wbc_q  <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            en_q  <= 1'b1;
            wbc_q <= wbc_d;
            if (gnt != 2'b00) last_q <= gnt[1];
        end
    end

    // payload storage needs no reset: occupancy qualifies every read
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) begin
                rd_q[p][wp_q[p]]  <= in_rd[p];
                dat_q[p][wp_q[p]] <= in_dat[p];
            end
        end
    end

    assign wb_count = wbc_q;
endmodule
